icache_fill_responder: RTL



---
 rtl/icache_fill_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/icache_fill_responder.sv
// Instruction-cache fill responder: arbitrates per-core fetch misses round-robin,
// performs one RAM word read per grant and returns the word with a one-cycle
// iwait-low strobe to the requesting core.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access in flight; grant next requester unless dmem_busy
// ACCESS | ramREN high on the latched address, waiting for ramready
// RESP   | iwait low for the served core, advance round-robin pointer
module icache_fill_responder #(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [32*CPUS-1:0]   iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [32*CPUS-1:0]   iload,
    output logic                 ramREN,
    output logic [31:0]          ramaddr,
    input  logic [31:0]          ramload,
    input  logic                 ramready,
    input  logic                 dmem_busy
);

    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] core_id;
    logic [PW-1:0] grant_id;
    logic          grant_valid;
    logic [PW:0]   cand;
    logic [31:0]   grant_addr;
    logic          grant_take;

    // Round-robin search: first requester at or above rr_ptr, wrapping mod CPUS.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < CPUS; i++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(CPUS)) begin
                cand = cand - (PW+1)'(CPUS);
            end
            if (!grant_valid && iREN[cand[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = cand[PW-1:0];
            end
        end
    end

    // Select the granted core's fetch address.
    always_comb begin
        grant_addr = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (grant_id == PW'(c)) begin
                grant_addr = iaddr[32*c +: 32];
            end
        end
    end

    assign grant_take = (state == IDLE) && !dmem_busy && grant_valid;

    // State register; reset aborts any in-flight access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an access, once started, always runs to its response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_take) state_next = ACCESS;
            ACCESS:  if (ramready)   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: RAM request, returned data, wait strobe, rr pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr  <= '0;
            core_id <= '0;
            iwait   <= '1;
            iload   <= '0;
            ramREN  <= 1'b0;
            ramaddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_take) begin
                        core_id <= grant_id;
                        ramaddr <= grant_addr;
                        ramREN  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (ramready) begin
                        ramREN <= 1'b0;
                        for (int c = 0; c < CPUS; c++) begin
                            if (core_id == PW'(c)) begin
                                iload[32*c +: 32] <= ramload;
                                iwait[c]          <= 1'b0;
                            end
                        end
                    end
                end
                RESP: begin
                    iwait  <= '1;
                    rr_ptr <= (core_id == PW'(CPUS-1)) ? '0 : core_id + PW'(1);
                end
                default: begin
                    iwait  <= '1;
                    ramREN <= 1'b0;
                end
            endcase
        end
    end

endmodule
